// File: rtl/chord_sequencer.sv
// chord_sequencer
//   Feeds the four-voice notes player. Walks a synchronous song ROM, groups
//   consecutive note words into chords of up to four notes, presents each
//   chord together with a load_new_note pulse, then waits for the player to
//   accept and finish the chord before fetching the next. Stops at the
//   all-zero end-of-song word.
//
// Parameters
//   ADDR_WIDTH : song ROM address width
//   START_ADDR : first ROM address read after reset or restart
//
// Ports
//   clk                  system clock
//   reset                asynchronous active-low reset
//   play                 1 = run, 0 = freeze in the current state
//   restart              one-cycle pulse: back to START_ADDR, clear song_done
//   done_with_note       player has finished the current chord
//   rom_data[15:0]       song word {chord_end, meta[2:0], dur[5:0], note[5:0]}
//   rom_addr             song ROM read address (1-cycle read latency)
//   note1..note4         chord notes, unused slots 0
//   metadata1..4         per-note metadata, unused slots 0
//   duration             chord duration in beats
//   num_notes            notes in chord minus 1
//   load_new_note        one-cycle pulse; chord outputs valid from this cycle
//   song_done            song finished; held until restart or reset
module chord_sequencer #(
    parameter int ADDR_WIDTH = 7,
    parameter int START_ADDR = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  play,
    input  logic                  restart,
    input  logic                  done_with_note,
    input  logic [15:0]           rom_data,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    output logic [5:0]            note1,
    output logic [5:0]            note2,
    output logic [5:0]            note3,
    output logic [5:0]            note4,
    output logic [2:0]            metadata1,
    output logic [2:0]            metadata2,
    output logic [2:0]            metadata3,
    output logic [2:0]            metadata4,
    output logic [5:0]            duration,
    output logic [1:0]            num_notes,
    output logic                  load_new_note,
    output logic                  song_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_READ,
        S_LOAD,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_DONE
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] START = ADDR_WIDTH'(START_ADDR);

    state_t                r_state;
    state_t                w_next;

    logic [ADDR_WIDTH-1:0] r_addr;
    logic [2:0]            r_cnt;          // notes staged so far, saturates at 4
    logic [5:0]            r_stg_note [4];
    logic [2:0]            r_stg_meta [4];
    logic [5:0]            r_stg_dur;

    logic [5:0]            r_note [4];     // output bank, written only in LOAD
    logic [2:0]            r_meta [4];
    logic [5:0]            r_dur;
    logic [1:0]            r_num;

    logic                  w_eos;
    logic                  w_chord_end;
    logic [5:0]            w_dur;
    logic                  w_last;
    logic                  w_store;
    logic                  w_load;
    logic [5:0]            w_chord_note [4];
    logic [2:0]            w_chord_meta [4];
    logic [1:0]            w_num;

    assign w_eos       = (rom_data == 16'h0000);
    assign w_chord_end = rom_data[15];
    assign w_dur       = rom_data[11:6];
    assign w_last      = (r_addr == {ADDR_WIDTH{1'b1}});
    assign w_store     = (r_cnt < 3'd4);
    assign w_num       = 2'(r_cnt - 3'd1);

    // Slots beyond the staged count may hold notes from an earlier chord;
    // mask them so unused voices always present 0.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_chord_note[i] = '0;
            w_chord_meta[i] = '0;
            if (3'(i) < r_cnt) begin
                w_chord_note[i] = r_stg_note[i];
                w_chord_meta[i] = r_stg_meta[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else if (restart) begin
            r_state <= S_IDLE;
        end else if (play) begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        case (r_state)
            S_IDLE:      w_next = S_ADDR;
            S_ADDR:      w_next = S_READ;
            S_READ: begin
                // The last address cannot advance, so the song ends there
                // rather than wrapping back to address 0.
                if (w_eos || w_last)
                    w_next = S_DONE;
                else if (w_chord_end && (w_dur != 6'd0))
                    w_next = S_LOAD;
                else
                    w_next = S_ADDR;
            end
            S_LOAD: begin
                w_next = S_WAIT_BUSY;
                // Held off while paused so the pulse only fires once play returns.
                w_load = play && !restart;
            end
            // A done still high from the previous chord must not count as
            // completion, so first see it drop, then see it rise.
            S_WAIT_BUSY: if (!done_with_note) w_next = S_WAIT_DONE;
            S_WAIT_DONE: if (done_with_note)  w_next = S_ADDR;
            S_DONE:      w_next = S_DONE;
            default:     w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_addr    <= START;
            r_cnt     <= '0;
            r_stg_dur <= '0;
            r_dur     <= '0;
            r_num     <= '0;
            for (int i = 0; i < 4; i++) begin
                r_stg_note[i] <= '0;
                r_stg_meta[i] <= '0;
                r_note[i]     <= '0;
                r_meta[i]     <= '0;
            end
        end else if (restart) begin
            r_addr <= START;
            r_cnt  <= '0;
        end else if (play) begin
            case (r_state)
                S_READ: begin
                    if (w_eos) begin
                        r_cnt <= '0;
                    end else begin
                        if (!w_last)
                            r_addr <= r_addr + 1'b1;
                        if (w_chord_end && (w_dur == 6'd0)) begin
                            // Zero-length chord is dropped; an empty count
                            // makes every staged slot read as unused.
                            r_cnt <= '0;
                        end else begin
                            if (w_store) begin
                                r_stg_note[r_cnt[1:0]] <= rom_data[5:0];
                                r_stg_meta[r_cnt[1:0]] <= rom_data[14:12];
                                r_cnt                  <= r_cnt + 3'd1;
                            end
                            if (w_chord_end)
                                r_stg_dur <= w_dur;
                        end
                    end
                end
                S_LOAD: begin
                    if (w_load) begin
                        for (int i = 0; i < 4; i++) begin
                            r_note[i] <= w_chord_note[i];
                            r_meta[i] <= w_chord_meta[i];
                        end
                        r_dur <= r_stg_dur;
                        r_num <= w_num;
                        r_cnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // During the pulse cycle the outputs show the chord being loaded, so
    // they are valid together with load_new_note; afterwards the bank holds it.
    assign note1     = w_load ? w_chord_note[0] : r_note[0];
    assign note2     = w_load ? w_chord_note[1] : r_note[1];
    assign note3     = w_load ? w_chord_note[2] : r_note[2];
    assign note4     = w_load ? w_chord_note[3] : r_note[3];
    assign metadata1 = w_load ? w_chord_meta[0] : r_meta[0];
    assign metadata2 = w_load ? w_chord_meta[1] : r_meta[1];
    assign metadata3 = w_load ? w_chord_meta[2] : r_meta[2];
    assign metadata4 = w_load ? w_chord_meta[3] : r_meta[3];
    assign duration  = w_load ? r_stg_dur : r_dur;
    assign num_notes = w_load ? w_num : r_num;

    assign load_new_note = w_load;
    assign song_done     = (r_state == S_DONE);
    assign rom_addr      = r_addr;

endmodule

// File: tb/tb_chord_sequencer.sv
module tb_chord_sequencer;

    localparam int AW = 7;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          play = 1'b0;
    logic          restart = 1'b0;
    logic          done_with_note = 1'b1;
    logic [15:0]   rom_data = 16'h0000;
    logic [AW-1:0] rom_addr;
    logic [5:0]    note1, note2, note3, note4;
    logic [2:0]    metadata1, metadata2, metadata3, metadata4;
    logic [5:0]    duration;
    logic [1:0]    num_notes;
    logic          load_new_note;
    logic          song_done;

    chord_sequencer #(.ADDR_WIDTH(AW), .START_ADDR(0)) dut (
        .clk            (clk),
        .reset          (reset),
        .play           (play),
        .restart        (restart),
        .done_with_note (done_with_note),
        .rom_data       (rom_data),
        .rom_addr       (rom_addr),
        .note1          (note1),
        .note2          (note2),
        .note3          (note3),
        .note4          (note4),
        .metadata1      (metadata1),
        .metadata2      (metadata2),
        .metadata3      (metadata3),
        .metadata4      (metadata4),
        .duration       (duration),
        .num_notes      (num_notes),
        .load_new_note  (load_new_note),
        .song_done      (song_done)
    );

    always #5 clk = ~clk;

    // Synchronous song ROM: one cycle read latency.
    logic [15:0] mem [DEPTH];
    always @(posedge clk) rom_data <= mem[rom_addr];

    typedef struct packed {
        logic [3:0][5:0] n;
        logic [3:0][2:0] m;
        logic [5:0]      d;
        logic [1:0]      k;
    } chord_t;

    chord_t exp_q[$];
    chord_t song_last;
    bit     song_has;
    chord_t hold_exp;
    int     exp_end;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic chord_t dut_chord();
        chord_t c;
        c.n = {note4, note3, note2, note1};
        c.m = {metadata4, metadata3, metadata2, metadata1};
        c.d = duration;
        c.k = num_notes;
        return c;
    endfunction

    function automatic logic [15:0] wd(input bit ce, input int meta, input int dur, input int note);
        return {ce, 3'(meta), 6'(dur), 6'(note)};
    endfunction

    // Reference: read the song as a list of words and cut it into chords.
    function automatic void model();
        chord_t c;
        int cnt;
        logic [15:0] w;
        c = '0;
        cnt = 0;
        song_has = 0;
        exp_end = DEPTH - 1;
        for (int a = 0; a < DEPTH; a++) begin
            w = mem[a];
            if (w == 16'h0000) begin
                exp_end = a;
                return;
            end
            if (cnt < 4) begin
                c.n[cnt] = w[5:0];
                c.m[cnt] = w[14:12];
                cnt++;
            end
            if (a == DEPTH - 1) begin
                exp_end = a;
                return;
            end
            if (w[15]) begin
                if (w[11:6] != 6'd0) begin
                    c.d = w[11:6];
                    c.k = 2'(cnt - 1);
                    exp_q.push_back(c);
                    song_last = c;
                    song_has = 1;
                end
                c = '0;
                cnt = 0;
            end
        end
    endfunction

    function automatic logic [15:0] rand_word(input bit ce);
        logic [15:0] w;
        w[15]    = ce;
        w[14:12] = 3'($urandom_range(0, 7));
        w[11:6]  = ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
        w[5:0]   = 6'($urandom_range(0, 63));
        if (w == 16'h0000) w[5:0] = 6'd1;
        return w;
    endfunction

    task automatic clear_mem();
        for (int a = 0; a < DEPTH; a++) mem[a] = 16'h0000;
    endtask

    // Player: after each load keeps a stale done high for a while, then
    // plays (done low), then reports completion (done high).
    int ph = 0;
    int pc = 0;
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (!reset) begin
                done_with_note = 1'b1;
                ph = 0;
            end else if (load_new_note) begin
                ph = 1;
                pc = $urandom_range(0, 5);
            end else if (ph == 1) begin
                if (pc == 0) begin
                    done_with_note = 1'b0;
                    ph = 2;
                    pc = $urandom_range(6, 9);
                end else pc--;
            end else if (ph == 2) begin
                if (pc == 0) begin
                    done_with_note = 1'b1;
                    ph = 0;
                end else pc--;
            end
        end
    end

    // Monitor: pops the scoreboard on every load pulse.
    bit pending = 0;
    bit low_seen = 0;
    always @(negedge clk) begin
        chord_t e;
        if (!reset || restart) begin
            pending  = 0;
            low_seen = 0;
        end else begin
            if (pending) begin
                if (!done_with_note) low_seen = 1;
                else if (low_seen) begin
                    pending  = 0;
                    low_seen = 0;
                end
            end
            if (load_new_note) begin
                check("load_while_paused", 64'(play), 64'd1);
                check("load_before_player_done", 64'(pending), 64'd0);
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL extra_load: got chord %0h, expected no load (t=%0t)", dut_chord(), $time);
                end else begin
                    e = exp_q.pop_front();
                    check("chord", 64'(dut_chord()), 64'(e));
                end
                pending  = 1;
                low_seen = 0;
            end
        end
    end

    task automatic start_song();
        model();
        restart = 1'b1;
        play    = 1'b1;
        @(posedge clk);
        #3;
        restart = 1'b0;
        check("restart_addr", 64'(rom_addr), 64'd0);
        check("restart_song_done", 64'(song_done), 64'd0);
        check("restart_holds_outputs", 64'(dut_chord()), 64'(hold_exp));
    endtask

    task automatic finish_song(input string nm, input bit pause_en);
        int cyc;
        int gap;
        logic [AW-1:0] a;
        cyc = 0;
        gap = 4;
        while (!song_done && cyc < 4000) begin
            if (pause_en && gap == 0 && $urandom_range(0, 11) == 0) begin
                play = 1'b0;
                a = rom_addr;
                repeat (3) begin
                    @(posedge clk);
                    #3;
                    cyc++;
                end
                check("pause_holds_addr", 64'(rom_addr), 64'(a));
                play = 1'b1;
                gap = 6;
            end else begin
                @(posedge clk);
                #3;
                cyc++;
                if (gap > 0) gap--;
            end
        end
        if (!song_done) begin
            vectors++;
            miscompares++;
            $display("FAIL %s_timeout: got song_done=0 after %0d cycles, expected 1", nm, cyc);
        end
        repeat (4) begin
            @(posedge clk);
            #3;
        end
        check({nm, "_song_done"}, 64'(song_done), 64'd1);
        check({nm, "_end_addr"}, 64'(rom_addr), 64'(exp_end));
        check({nm, "_chords_left"}, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        if (song_has) hold_exp = song_last;
    endtask

    task automatic run_song(input string nm, input bit pause_en);
        start_song();
        finish_song(nm, pause_en);
    endtask

    initial begin
        int len;
        int cyc;
        hold_exp = '0;
        clear_mem();
        #1;
        check("reset_addr", 64'(rom_addr), 64'd0);
        check("reset_chord", 64'(dut_chord()), 64'd0);
        check("reset_load", 64'(load_new_note), 64'd0);
        check("reset_song_done", 64'(song_done), 64'd0);
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b1;

        // Single note
        clear_mem();
        mem[0] = wd(1, 0, 12, 20);
        run_song("single", 0);

        // Three-note chord with per-slot metadata
        clear_mem();
        mem[0] = wd(0, 1, 0, 10);
        mem[1] = wd(0, 2, 0, 14);
        mem[2] = wd(1, 5, 8, 17);
        run_song("triad", 0);

        // Six notes in one chord, then a following chord
        clear_mem();
        for (int i = 0; i < 5; i++) mem[i] = wd(0, i + 1, 0, 30 + i);
        mem[5] = wd(1, 7, 5, 40);
        mem[6] = wd(1, 3, 3, 33);
        run_song("overflow", 0);

        // End-of-song in the middle of a chord
        clear_mem();
        mem[0] = wd(0, 2, 0, 9);
        run_song("eos_mid", 0);

        // Zero-duration chord is skipped; rest note counts as a voice
        clear_mem();
        mem[0] = wd(0, 1, 0, 5);
        mem[1] = wd(1, 2, 0, 6);
        mem[2] = wd(0, 4, 0, 0);
        mem[3] = wd(1, 6, 63, 63);
        run_song("zero_dur", 1);

        // Random songs with random pauses and player timing; replay each via restart
        for (int s = 0; s < 8; s++) begin
            clear_mem();
            len = $urandom_range(8, 40);
            for (int a = 0; a < len; a++)
                mem[a] = rand_word($urandom_range(0, 2) == 0);
            run_song("random", 1);
            if (s % 3 == 0) run_song("replay", 1);
        end

        // Reset while waiting for the player to finish
        clear_mem();
        mem[0] = wd(0, 1, 0, 11);
        mem[1] = wd(1, 3, 20, 12);
        mem[2] = wd(1, 4, 21, 13);
        start_song();
        cyc = 0;
        while (!load_new_note && cyc < 500) begin
            @(posedge clk);
            #3;
            cyc++;
        end
        while (done_with_note && cyc < 500) begin
            @(posedge clk);
            #3;
            cyc++;
        end
        check("reached_wait_done", 64'(cyc < 500), 64'd1);
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check("midreset_chord", 64'(dut_chord()), 64'd0);
        check("midreset_addr", 64'(rom_addr), 64'd0);
        check("midreset_load", 64'(load_new_note), 64'd0);
        check("midreset_song_done", 64'(song_done), 64'd0);
        exp_q.delete();
        hold_exp = '0;
        @(posedge clk);
        #3;
        reset = 1'b1;
        run_song("after_reset", 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/chord_sequencer.md
Name: chord_sequencer

Overview:
- Upstream feeder for the four-voice notes player.
- Walks a synchronous song ROM and groups consecutive note words into chords of 1–4 notes.
- Presents each chord's notes, per-note metadata, a shared duration and the note count, then pulses load_new_note.
- Waits for the player to finish the chord before fetching the next one; stops at the end-of-song word.

Parameters:
- ADDR_WIDTH, 7, song ROM address width (song length up to 2^ADDR_WIDTH words).
- START_ADDR, 0, first ROM address read after reset or restart.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- play  input  1  1 = run; 0 = freeze FSM in current state
- restart  input  1  one-cycle pulse; return to START_ADDR and clear song_done
- done_with_note  input  1  from notes player; high when current chord finished
- rom_data  input  16  song word: [15] chord_end, [14:12] metadata, [11:6] duration, [5:0] note (0 = rest)
- rom_addr  output  ADDR_WIDTH  song ROM read address
- note1..note4  output  6 each  chord notes; unused slots = 0
- metadata1..metadata4  output  3 each  per-note metadata; unused slots = 0
- duration  output  6  chord duration in beats
- num_notes  output  2  notes in chord minus 1
- load_new_note  output  1  one-cycle pulse; chord outputs valid and stable from this cycle until the next pulse
- song_done  output  1  high once the song has ended; held until restart or reset

Behaviour:
- Reset (reset=0, async): state IDLE; rom_addr=START_ADDR; all note/metadata/duration/num_notes=0; load_new_note=0; song_done=0; slot counter=0.
- States: IDLE, ADDR, READ, LOAD, WAIT_BUSY, WAIT_DONE, DONE.
- IDLE -> ADDR when play=1.
- ROM latency: rom_addr is driven in ADDR; rom_data is sampled in READ on the next cycle.
- READ, end-of-song word (rom_data==16'h0000): discard any partial chord, go DONE.
- READ, other words: write note and metadata into slot[count] only if count<4; extra notes beyond 4 are dropped silently.
- READ, count update: count saturates at 4 and increments only when a note was stored.
- READ, chord_end=0: rom_addr+1, go ADDR.
- READ, chord_end=1: latch duration from this word; rom_addr+1; go LOAD, or skip straight to ADDR if duration==0 (chord discarded, slots cleared).
- Address wrap: if rom_addr==2^ADDR_WIDTH-1 when READ would advance, go DONE instead of wrapping.
- LOAD: drive registered chord outputs with num_notes=count-1; pulse load_new_note for exactly 1 cycle; clear the staging count; go WAIT_BUSY.
- Chord outputs come from a separate output register bank loaded only in LOAD. Staging of the next chord never disturbs the outputs.
- WAIT_BUSY: wait for done_with_note==0 (player accepted the chord), then WAIT_DONE.
- WAIT_DONE: wait for done_with_note==1, then ADDR.
- Net effect of WAIT_BUSY/WAIT_DONE: a stale done high in the cycle after load is never mistaken for completion.
- DONE: song_done=1; outputs hold their last values; no ROM reads.
- Pause (play=0): every state holds and registers keep their values. A load_new_note pulse is never emitted while play=0. If play falls in LOAD, the pulse is deferred until play=1.
- restart=1 (any state, priority over play): next state IDLE; rom_addr=START_ADDR; staging count=0; song_done=0. Chord outputs keep their values until the next LOAD.
- Simultaneous restart and a done_with_note rise: restart wins.
- Reset mid-operation: immediate return to the reset values; no partial pulse.

Test Plan:
- Single-note song: ROM[0]=chord_end,meta 0,dur 12,note 20; ROM[1]=0. Play=1 -> one load pulse with note1=20, note2..4=0, duration=12, num_notes=0. After done_with_note low→high, song_done=1 and rom_addr stops at 1.
- 3-note chord: notes 10, 14, 17 (last with chord_end, dur 8) -> num_notes=2, note1..3=10/14/17, note4=0, metadata routed per slot, exactly one load pulse.
- Overflow: 6 note words, chord_end on the 6th -> only the first 4 loaded, num_notes=3; the next chord starts at word 6.
- End-of-song mid-chord: note word without chord_end followed by 16'h0000 -> no load pulse; song_done=1.
- Handshake and pause: hold done_with_note=1 for 5 cycles after a load -> no refetch until done goes low then high. Drop play during WAIT_DONE -> state frozen; resumes on play=1.
- Reset/restart: assert reset=0 in WAIT_DONE -> outputs zero immediately. Pulse restart after song_done -> song_done=0, rom_addr=START_ADDR, and the song replays identically.
